// File: rtl/mc_page_seq.sv
// mc_page_seq: bank/row command sequencer, PRE/ACT/RD/WR and PREA/REF.
// Define MC_CLOSED_PAGE_EN for the closed-page (auto-precharge) policy.

module mc_page_seq #(
    parameter int LOOKUP_LAT = 2,
    parameter int TW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          req_we,
    input  logic [7:0]    req_cs,
    input  logic [12:0]   req_row,
    input  logic [1:0]    req_bank,
    output logic          req_ack,
    input  logic          rfr_req,
    output logic          rfr_ack,
    input  logic [TW-1:0] trp,
    input  logic [TW-1:0] trcd,
    input  logic [TW-1:0] trfc,
    output logic [7:0]    cs,
    output logic [12:0]   row_adr,
    output logic [1:0]    bank_adr,
    output logic          bank_set,
    output logic          bank_clr,
    output logic          bank_clr_all,
    input  logic          bank_open,
    input  logic          row_same,
    input  logic          any_bank_open,
    output logic [2:0]    cmd,
    output logic          cmd_ap
);

    localparam int LW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
    localparam logic [LW-1:0] LK_INIT = LW'(LOOKUP_LAT - 1);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_PRE  = 3'd2;
    localparam logic [2:0] CMD_PREA = 3'd3;
    localparam logic [2:0] CMD_RD   = 3'd4;
    localparam logic [2:0] CMD_WR   = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DECIDE,
        S_PRE_WAIT,
        S_ACT_WAIT,
        S_HOLD_WAIT,
        S_PREA_WAIT,
        S_REF_WAIT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] wcnt;
    logic [TW-1:0] wcnt_n;
    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_n;

    logic          lat_rfr;
    logic          lat_we;
    logic [7:0]    lat_cs;
    logic [12:0]   lat_row;
    logic [1:0]    lat_bank;

    logic          accept_req;
    logic          accept_rfr;
    logic          do_pre;
    logic          do_act;
    logic          do_col;
    logic          do_prea;
    logic          do_ref;

    // Wait length for a timing value: a zero setting behaves as one cycle.
    function automatic logic [TW-1:0] tmin1(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // State register and wait/lookup counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            lcnt  <= lcnt_n;
        end
    end

    // Capture the accepted request (or refresh target) for the whole sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rfr  <= 1'b0;
            lat_we   <= 1'b0;
            lat_cs   <= '0;
            lat_row  <= '0;
            lat_bank <= '0;
        end else if (accept_rfr) begin
            lat_rfr  <= 1'b1;
            lat_we   <= 1'b0;
            lat_cs   <= 8'hFF;
            lat_row  <= '0;
            lat_bank <= '0;
        end else if (accept_req) begin
            lat_rfr  <= 1'b0;
            lat_we   <= req_we;
            lat_cs   <= req_cs;
            lat_row  <= req_row;
            lat_bank <= req_bank;
        end
    end

    // Next-state, command issue and tracker-side outputs.
    always_comb begin
        state_n      = state;
        wcnt_n       = wcnt;
        lcnt_n       = lcnt;
        accept_req   = 1'b0;
        accept_rfr   = 1'b0;
        do_pre       = 1'b0;
        do_act       = 1'b0;
        do_col       = 1'b0;
        do_prea      = 1'b0;
        do_ref       = 1'b0;
        cmd          = CMD_NOP;
        cmd_ap       = 1'b0;
        req_ack      = 1'b0;
        rfr_ack      = 1'b0;
        bank_set     = 1'b0;
        bank_clr     = 1'b0;
        bank_clr_all = 1'b0;
        cs           = '0;
        row_adr      = '0;
        bank_adr     = '0;

        if (state != S_IDLE) begin
            cs       = lat_cs;
            row_adr  = lat_row;
            bank_adr = lat_bank;
        end

        case (state)
            S_IDLE: begin
                if (rfr_req) begin
                    accept_rfr = 1'b1;
                    lcnt_n     = LK_INIT;
                    state_n    = S_LOOKUP;
                end else if (req) begin
                    accept_req = 1'b1;
                    lcnt_n     = LK_INIT;
                    state_n    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lcnt == '0) begin
                    state_n = S_DECIDE;
                end else begin
                    lcnt_n = lcnt - LW'(1);
                end
            end
            S_DECIDE: begin
                if (lat_rfr) begin
                    if (any_bank_open) begin
                        do_prea = 1'b1;
                    end else begin
                        do_ref = 1'b1;
                    end
                end else if (bank_open && row_same) begin
                    do_col = 1'b1;
                end else if (bank_open) begin
                    do_pre = 1'b1;
                end else begin
                    do_act = 1'b1;
                end
            end
            S_PRE_WAIT: begin
                if (wcnt == '0) begin
                    do_act = 1'b1;
                end else begin
                    wcnt_n = wcnt - TW'(1);
                end
            end
            S_ACT_WAIT: begin
                if (wcnt == '0) begin
                    do_col = 1'b1;
                end else begin
                    wcnt_n = wcnt - TW'(1);
                end
            end
            S_PREA_WAIT: begin
                if (wcnt == '0) begin
                    do_ref = 1'b1;
                end else begin
                    wcnt_n = wcnt - TW'(1);
                end
            end
            S_HOLD_WAIT, S_REF_WAIT: begin
                if (wcnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    wcnt_n = wcnt - TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (do_pre) begin
            cmd      = CMD_PRE;
            bank_clr = 1'b1;
            wcnt_n   = tmin1(trp);
            state_n  = S_PRE_WAIT;
        end

        if (do_act) begin
            cmd      = CMD_ACT;
            bank_set = 1'b1;
            wcnt_n   = tmin1(trcd);
            state_n  = S_ACT_WAIT;
        end

        if (do_col) begin
            cmd     = lat_we ? CMD_WR : CMD_RD;
            req_ack = 1'b1;
`ifdef MC_CLOSED_PAGE_EN
            cmd_ap   = 1'b1;
            bank_clr = 1'b1;
            wcnt_n   = tmin1(trp);
            state_n  = S_HOLD_WAIT;
`else
            state_n = S_IDLE;
`endif
        end

        if (do_prea) begin
            cmd          = CMD_PREA;
            bank_clr_all = 1'b1;
            wcnt_n       = tmin1(trp);
            state_n      = S_PREA_WAIT;
        end

        if (do_ref) begin
            cmd     = CMD_REF;
            rfr_ack = 1'b1;
            wcnt_n  = tmin1(trfc);
            state_n = S_REF_WAIT;
        end
    end

endmodule

// File: tb/tb_mc_page_seq.sv
// tb_mc_page_seq: bench for mc_page_seq with a bank/row tracker stand-in
// and a cycle-offset command model of each access/refresh sequence.

module tb_mc_page_seq;

    localparam int LAT = 2;
    localparam int TW  = 4;
`ifdef MC_CLOSED_PAGE_EN
    localparam bit CP = 1'b1;
`else
    localparam bit CP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req;
    logic          req_we;
    logic [7:0]    req_cs;
    logic [12:0]   req_row;
    logic [1:0]    req_bank;
    logic          req_ack;
    logic          rfr_req;
    logic          rfr_ack;
    logic [TW-1:0] trp;
    logic [TW-1:0] trcd;
    logic [TW-1:0] trfc;
    logic [7:0]    cs;
    logic [12:0]   row_adr;
    logic [1:0]    bank_adr;
    logic          bank_set;
    logic          bank_clr;
    logic          bank_clr_all;
    logic          bank_open;
    logic          row_same;
    logic          any_bank_open;
    logic [2:0]    cmd;
    logic          cmd_ap;

    int n_vec;
    int n_err;

    mc_page_seq #(.LOOKUP_LAT(LAT), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_we(req_we), .req_cs(req_cs),
        .req_row(req_row), .req_bank(req_bank), .req_ack(req_ack),
        .rfr_req(rfr_req), .rfr_ack(rfr_ack),
        .trp(trp), .trcd(trcd), .trfc(trfc),
        .cs(cs), .row_adr(row_adr), .bank_adr(bank_adr),
        .bank_set(bank_set), .bank_clr(bank_clr), .bank_clr_all(bank_clr_all),
        .bank_open(bank_open), .row_same(row_same), .any_bank_open(any_bank_open),
        .cmd(cmd), .cmd_ap(cmd_ap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tracker stand-in: per chip/bank open flag and row, status delayed LAT cycles.
    logic        t_open [8][4];
    logic [12:0] t_row  [8][4];
    logic [2:0]  t_pipe [LAT];
    logic [2:0]  t_cur;

    always_comb begin
        t_cur = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (cs[i]) begin
                if (t_open[i][bank_adr]) t_cur[2] = 1'b1;
                if (t_open[i][bank_adr] && t_row[i][bank_adr] == row_adr) t_cur[1] = 1'b1;
                for (int b = 0; b < 4; b++) if (t_open[i][b]) t_cur[0] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                for (int b = 0; b < 4; b++) t_open[i][b] <= 1'b0;
            for (int k = 0; k < LAT; k++) t_pipe[k] <= 3'b000;
        end else begin
            t_pipe[0] <= t_cur;
            for (int k = 1; k < LAT; k++) t_pipe[k] <= t_pipe[k-1];
            for (int i = 0; i < 8; i++) begin
                if (cs[i]) begin
                    if (bank_set) begin
                        t_open[i][bank_adr] <= 1'b1;
                        t_row[i][bank_adr]  <= row_adr;
                    end
                    if (bank_clr) t_open[i][bank_adr] <= 1'b0;
                    if (bank_clr_all || rfr_ack)
                        for (int b = 0; b < 4; b++) t_open[i][b] <= 1'b0;
                end
            end
        end
    end

    assign {bank_open, row_same, any_bank_open} = t_pipe[LAT-1];

    // Reference view of open rows, kept from the sequencing rules alone.
    bit          m_open [8][4];
    logic [12:0] m_row  [8][4];

    task automatic m_clear();
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 4; b++) m_open[i][b] = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Apply one access or refresh at a negedge while the DUT is idle and
    // check every cycle until it is idle again.
    task automatic run_txn(
        input bit is_rfr, input bit both, input bit we,
        input logic [7:0] c, input logic [12:0] r, input logic [1:0] b,
        input logic [3:0] p, input logic [3:0] cd, input logic [3:0] f,
        output logic [2:0] first_cmd, output int ack_off);
        int e [64];
        int tp, tc, tf, ci, d, x, col, fin;
        bit any;
        logic [2:0] ec;
        logic [8:0] av, ev;
        tp = (p == 0) ? 1 : int'(p);
        tc = (cd == 0) ? 1 : int'(cd);
        tf = (f == 0) ? 1 : int'(f);
        for (int k = 0; k < 64; k++) e[k] = 0;
        ci = 0;
        for (int i = 0; i < 8; i++) if (c[i]) ci = i;
        d = LAT + 1;
        if (is_rfr) begin
            any = 1'b0;
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < 4; k++) if (m_open[i][k]) any = 1'b1;
            if (any) begin
                e[d] = 3;
                x = d + tp;
            end else begin
                x = d;
            end
            e[x] = 6;
            fin = x + tf + 1;
            m_clear();
        end else begin
            if (m_open[ci][b] && m_row[ci][b] == r) begin
                col = d;
            end else if (m_open[ci][b]) begin
                e[d] = 2;
                x = d + tp;
                e[x] = 1;
                col = x + tc;
            end else begin
                e[d] = 1;
                col = d + tc;
            end
            e[col] = we ? 5 : 4;
            if (CP) begin
                m_open[ci][b] = 1'b0;
                fin = col + tp + 1;
            end else begin
                m_open[ci][b] = 1'b1;
                m_row[ci][b]  = r;
                fin = col + 1;
            end
        end

        trp = p;
        trcd = cd;
        trfc = f;
        rfr_req = is_rfr;
        if (!is_rfr || both) begin
            req = 1'b1;
            req_we = we;
            req_cs = c;
            req_row = r;
            req_bank = b;
        end else begin
            req = 1'b0;
        end

        first_cmd = 3'd0;
        ack_off = -1;
        for (int off = 1; off <= fin; off++) begin
            @(negedge clk);
            ec = 3'(e[off]);
            av = {cmd, bank_set, bank_clr, bank_clr_all, req_ack, rfr_ack, cmd_ap};
            ev = {ec, ec == 3'd1,
                  ec == 3'd2 || (CP && (ec == 3'd4 || ec == 3'd5)),
                  ec == 3'd3, ec == 3'd4 || ec == 3'd5, ec == 3'd6,
                  CP && (ec == 3'd4 || ec == 3'd5)};
            chk($sformatf("cmd off%0d", off), 32'(av), 32'(ev));
            chk($sformatf("cs off%0d", off), 32'(cs),
                (off < fin) ? (is_rfr ? 32'hFF : 32'(c)) : 32'h0);
            if (!is_rfr)
                chk($sformatf("adr off%0d", off), {17'h0, row_adr, bank_adr},
                    (off < fin) ? {17'h0, r, b} : 32'h0);
            if (first_cmd == 3'd0 && cmd != 3'd0) first_cmd = cmd;
            if ((req_ack || rfr_ack) && ack_off < 0) ack_off = off;
            if (req_ack) req = 1'b0;
            if (rfr_ack) rfr_req = 1'b0;
        end
        rfr_req = 1'b0;
        if (!both) req = 1'b0;
    endtask

    typedef struct {
        bit          rfr;
        bit          both;
        bit          we;
        logic [7:0]  c;
        logic [12:0] r;
        logic [1:0]  b;
        logic [3:0]  p;
        logic [3:0]  cd;
        logic [3:0]  f;
        logic [2:0]  x_first;
        int          x_ack;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [2:0] fc;
        int ao;
        n_vec = 0;
        n_err = 0;

        tbl[0]  = '{0, 0, 0, 8'h01, 13'h123, 2, 2, 3, 5, 3'd1, 6};
        tbl[1]  = '{0, 0, 0, 8'h01, 13'h123, 2, 2, 3, 5,
                    CP ? 3'd1 : 3'd4, CP ? 6 : 3};
        tbl[2]  = '{0, 0, 1, 8'h01, 13'h124, 2, 2, 3, 5,
                    CP ? 3'd1 : 3'd2, CP ? 6 : 8};
        tbl[3]  = '{1, 1, 0, 8'h01, 13'h123, 2, 2, 3, 5,
                    CP ? 3'd6 : 3'd3, CP ? 3 : 5};
        tbl[4]  = '{0, 0, 0, 8'h01, 13'h123, 2, 2, 3, 5, 3'd1, 6};
        tbl[5]  = '{1, 0, 0, 8'h00, 13'h000, 0, 3, 3, 2,
                    CP ? 3'd6 : 3'd3, CP ? 3 : 6};
        tbl[6]  = '{1, 0, 0, 8'h00, 13'h000, 0, 3, 3, 0, 3'd6, 3};
        tbl[7]  = '{0, 0, 0, 8'h02, 13'h055, 1, 2, 0, 1, 3'd1, 4};
        tbl[8]  = '{0, 0, 0, 8'h02, 13'h056, 1, 0, 1, 1,
                    CP ? 3'd1 : 3'd2, CP ? 4 : 5};
        tbl[9]  = '{0, 0, 1, 8'h02, 13'h056, 1, 1, 1, 1,
                    CP ? 3'd1 : 3'd5, CP ? 4 : 3};
        tbl[10] = '{0, 0, 0, 8'h80, 13'h1FFF, 3, 15, 15, 15, 3'd1, 18};
        tbl[11] = '{1, 0, 0, 8'h00, 13'h000, 0, 1, 1, 1,
                    CP ? 3'd6 : 3'd3, CP ? 3 : 4};

        rst = 1'b1;
        req = 1'b0;
        req_we = 1'b0;
        req_cs = '0;
        req_row = '0;
        req_bank = '0;
        rfr_req = 1'b0;
        trp = '0;
        trcd = '0;
        trfc = '0;
        m_clear();
        repeat (3) @(negedge clk);
        chk("reset outputs",
            32'({cmd, bank_set, bank_clr, bank_clr_all, req_ack, rfr_ack, cmd_ap, cs, row_adr, bank_adr}),
            32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].rfr, tbl[i].both, tbl[i].we, tbl[i].c, tbl[i].r, tbl[i].b,
                    tbl[i].p, tbl[i].cd, tbl[i].f, fc, ao);
            chk($sformatf("tbl%0d first cmd", i), 32'(fc), 32'(tbl[i].x_first));
            chk($sformatf("tbl%0d ack offset", i), ao, tbl[i].x_ack);
        end

        req = 1'b1;
        req_we = 1'b0;
        req_cs = 8'h04;
        req_row = 13'h007;
        req_bank = 2'd0;
        trp = 4'd2;
        trcd = 4'd6;
        repeat (LAT + 1) @(negedge clk);
        chk("rst seq act", 32'({cmd, bank_set}), 32'({3'd1, 1'b1}));
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("mid-wait reset outputs",
            32'({cmd, bank_set, bank_clr, bank_clr_all, req_ack, rfr_ack, cmd_ap, cs, row_adr, bank_adr}),
            32'h0);
        rst = 1'b0;
        m_clear();
        run_txn(0, 0, 0, 8'h04, 13'h007, 2'd0, 4'd2, 4'd6, 4'd1, fc, ao);
        chk("after reset first cmd", 32'(fc), 32'd1);

        for (int n = 0; n < 150; n++) begin
            bit rf;
            rf = ($urandom_range(0, 9) == 0);
            run_txn(rf, 1'b0, 1'($urandom_range(0, 1)),
                    8'h01 << $urandom_range(0, 1),
                    13'h010 + 13'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                    4'($urandom_range(0, 5)), fc, ao);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
